// File: rtl/piano_pkg.sv
// -----------------------------------------------------------------------------
// piano_pkg
// Shared definitions for the digital note synthesiser:
//   env_state_t  - envelope FSM state encoding
//   *_BIT/_MSB/_LSB - bit positions of the fields in the 32-bit SPI word
//   WAVE_MID     - offset-binary midscale (silence)
//   shape_sample - triangle shaping and envelope scaling of one phase value
// -----------------------------------------------------------------------------
package piano_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ATTACK  = 2'd1,
        ST_SUSTAIN = 2'd2,
        ST_RELEASE = 2'd3
    } env_state_t;

    localparam int KEY_ON_BIT = 31;
    localparam int IGN_MSB    = 30;
    localparam int IGN_LSB    = 28;
    localparam int VOL_MSB    = 27;
    localparam int VOL_LSB    = 24;
    localparam int TUNE_MSB   = 23;
    localparam int TUNE_LSB   = 0;

    localparam logic [5:0] WAVE_MID = 6'd32;

    // Triangle from the top 7 phase bits, centred to -32..31, scaled by env/16.
    // The arithmetic shift floors, so the result stays within -30..29 and the
    // offset-binary output within 2..61.
    function automatic logic [5:0] shape_sample(input logic [31:0] phase,
                                                input logic [3:0]  env);
        logic [5:0]         tri_val;
        logic signed [6:0]  centred;
        logic signed [11:0] centred_ext;
        logic signed [11:0] env_ext;
        logic signed [11:0] product;
        logic signed [11:0] scaled;
        tri_val     = phase[31] ? ~phase[30:25] : phase[30:25];
        centred     = $signed({1'b0, tri_val}) - 7'sd32;
        centred_ext = {{5{centred[6]}}, centred};
        env_ext     = $signed({8'd0, env});
        product     = centred_ext * env_ext;
        scaled      = product >>> 4;
        // scaled fits in 6-bit two's complement; adding midscale modulo 64
        // converts it to offset binary.
        return scaled[5:0] + WAVE_MID;
    endfunction

endpackage

// File: rtl/sync_edge.sv
// -----------------------------------------------------------------------------
// sync_edge
// Two-flop synchroniser for an asynchronous level, followed by a rising-edge
// detector that emits a registered one-clock pulse per rising edge.
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   async_in in   level from another clock domain
//   pulse    out  one-cycle pulse per synchronised rising edge
// A level that is already high when reset is released never produces a pulse:
// the detector only arms after it has seen the synchronised input low once the
// synchroniser pipeline has been refilled with real samples.
// -----------------------------------------------------------------------------
module sync_edge (
    input  logic clk,
    input  logic reset_n,
    input  logic async_in,
    output logic pulse
);

    logic       meta_q,     meta_d;
    logic       sync_q,     sync_d;
    logic       sync_dly_q, sync_dly_d;
    logic [1:0] settle_q,   settle_d;
    logic       armed_q,    armed_d;
    logic       pulse_q,    pulse_d;

    always_comb begin
        meta_d     = async_in;
        sync_d     = meta_q;
        sync_dly_d = sync_q;
        // settle_q[1] set means sync_q now holds a post-reset sample.
        settle_d   = {settle_q[0], 1'b1};
        armed_d    = armed_q | (settle_q[1] & ~sync_q);
        pulse_d    = sync_q & ~sync_dly_q & armed_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q     <= 1'b0;
            sync_q     <= 1'b0;
            sync_dly_q <= 1'b0;
            settle_q   <= 2'b00;
            armed_q    <= 1'b0;
            pulse_q    <= 1'b0;
        end else begin
            meta_q     <= meta_d;
            sync_q     <= sync_d;
            sync_dly_q <= sync_dly_d;
            settle_q   <= settle_d;
            armed_q    <= armed_d;
            pulse_q    <= pulse_d;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/digital_note_synth.sv
// -----------------------------------------------------------------------------
// digital_note_synth
// Single-voice triangle synthesiser with an attack/sustain/release envelope,
// programmed by 32-bit words from an SPI receiver.
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   spi_word in   [31] key_on, [27:24] volume, [23:0] tune (phase increment)
//   load     in   asynchronous frame-complete strobe (level, >= 3 clk high)
//   wave     out  registered 6-bit offset-binary sample, 32 = silence
//   busy     out  envelope not idle
// Parameter RATE_DIV: clk cycles per envelope step (2..65535).
// -----------------------------------------------------------------------------
module digital_note_synth
    import piano_pkg::*;
#(
    parameter int unsigned RATE_DIV = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] spi_word,
    input  logic        load,
    output logic [5:0]  wave,
    output logic        busy
);

    localparam logic [15:0] PRESC_LAST = 16'(RATE_DIV - 1);

    logic        capture;
    logic        tick;
    logic [15:0] presc_q,  presc_d;
    env_state_t  state_q,  state_d;
    logic [3:0]  env_q,    env_d;
    logic [3:0]  volume_q, volume_d;
    logic [23:0] tune_q,   tune_d;
    logic [31:0] phase_q,  phase_d;
    logic [5:0]  wave_q,   wave_d;

    logic        key_on_in;
    logic [3:0]  volume_in;
    logic [23:0] tune_in;
    logic [3:0]  env_step;
    logic        unused_word_bits;

    sync_edge u_sync_edge (
        .clk      (clk),
        .reset_n  (reset_n),
        .async_in (load),
        .pulse    (capture)
    );

    assign key_on_in        = spi_word[KEY_ON_BIT];
    assign volume_in        = spi_word[VOL_MSB:VOL_LSB];
    assign tune_in          = spi_word[TUNE_MSB:TUNE_LSB];
    assign unused_word_bits = ^spi_word[IGN_MSB:IGN_LSB];

    assign tick     = (presc_q == PRESC_LAST);
    assign env_step = (env_q < volume_q) ? env_q + 4'd1 : env_q - 4'd1;

    always_comb begin
        presc_d  = tick ? 16'd0 : presc_q + 16'd1;
        state_d  = state_q;
        env_d    = env_q;
        volume_d = volume_q;
        tune_d   = tune_q;

        if (capture) begin
            volume_d = volume_in;
            tune_d   = tune_in;
        end

        // A capture always takes priority; any tick in that cycle is dropped.
        case (state_q)
            ST_IDLE: begin
                env_d = 4'd0;
                if (capture && key_on_in) begin
                    state_d = ST_ATTACK;
                end
            end
            ST_ATTACK: begin
                if (capture) begin
                    state_d = key_on_in ? ST_ATTACK : ST_RELEASE;
                end else if (env_q == volume_q) begin
                    state_d = ST_SUSTAIN;
                end else if (tick) begin
                    env_d = env_step;
                    if (env_step == volume_q) begin
                        state_d = ST_SUSTAIN;
                    end
                end
            end
            ST_SUSTAIN: begin
                if (capture) begin
                    if (!key_on_in) begin
                        state_d = ST_RELEASE;
                    end else if (volume_in != volume_q) begin
                        state_d = ST_ATTACK;
                    end
                end
            end
            ST_RELEASE: begin
                if (capture) begin
                    if (key_on_in) begin
                        state_d = ST_ATTACK;
                    end
                end else if (env_q == 4'd0) begin
                    state_d = ST_IDLE;
                end else if (tick) begin
                    env_d = env_q - 4'd1;
                    if (env_q == 4'd1) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                env_d   = 4'd0;
            end
        endcase

        // Phase runs only while a note is active and never clears on re-tune.
        if (state_d == ST_IDLE) begin
            phase_d = 32'd0;
        end else begin
            phase_d = phase_q + {8'd0, tune_d};
        end

        // The output register tracks the next phase/env so it always matches
        // the state registers it is presented alongside.
        wave_d = shape_sample(phase_d, env_d);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q  <= 16'd0;
            state_q  <= ST_IDLE;
            env_q    <= 4'd0;
            volume_q <= 4'd0;
            tune_q   <= 24'd0;
            phase_q  <= 32'd0;
            wave_q   <= WAVE_MID;
        end else begin
            presc_q  <= presc_d;
            state_q  <= state_d;
            env_q    <= env_d;
            volume_q <= volume_d;
            tune_q   <= tune_d;
            phase_q  <= phase_d;
            wave_q   <= wave_d;
        end
    end

    assign wave = wave_q;
    assign busy = (state_q != ST_IDLE);

endmodule

// File: doc/digital_note_synth.md
DIGITAL_NOTE_SYNTH -- requirements
Module: digital_note_synth

Interface
REQ-001 Parameter RATE_DIV, default 1024, clk cycles per envelope step (legal 2..65535).
REQ-002 clk  input  1  system clock; all state on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 spi_word  input  32  word from the SPI receive shift register; the master holds it stable while load is high.
REQ-005 load  input  1  frame-complete strobe from the master, asynchronous to clk; high at least 3 clk periods.
REQ-006 wave  output  6  unsigned offset-binary sample; midscale 32 is silence.
REQ-007 busy  output  1  high whenever the envelope state is not IDLE.

Function
REQ-008 Word fields: [31] key_on; [30:28] ignored; [27:24] volume (0..15); [23:0] tune (phase increment).
REQ-009 load passes through a 2-FF synchronizer; one rising edge of the synchronized load yields exactly one capture pulse, regardless of how long load stays high.
REQ-010 On a capture pulse, spi_word is latched; the first wave sample reflecting it appears 4 clk after load rises at the synchronizer input.
REQ-011 The 32-bit phase accumulator adds zero-extended tune every clk, wrapping modulo 2^32; a new tune takes effect without clearing phase.
REQ-012 Triangle: t = phase[31] ? ~phase[30:25] : phase[30:25], 6 bits unsigned; s = t - 32, signed, range -32..31.
REQ-013 wave = ((s * env) >>> 4) + 32, with env 0..15; the arithmetic shift rounds toward negative infinity; wave range is 2..61 and is registered.
REQ-014 A tick prescaler counts 0..RATE_DIV-1 and issues one tick on wrap; it runs freely and is not cleared by capture.
REQ-015 Envelope FSM states are IDLE, ATTACK, SUSTAIN, RELEASE.
REQ-016 IDLE: env=0, phase held at 0; capture with key_on=1 -> ATTACK; capture with key_on=0 -> stay IDLE, fields latched.
REQ-017 ATTACK: on each tick, env moves 1 toward volume, up or down; when env equals volume after a step or on entry -> SUSTAIN.
REQ-018 SUSTAIN: env held; capture with key_on=1 and a different volume -> ATTACK; capture with key_on=0 -> RELEASE.
REQ-019 RELEASE: env decrements 1 per tick; when env reaches 0 -> IDLE.
REQ-020 A capture with key_on=1 in RELEASE or ATTACK -> ATTACK, starting from the current env (no reset to 0).
REQ-021 A capture with key_on=0 in ATTACK -> RELEASE.
REQ-022 volume=0 with key_on=1: ATTACK ramps env to 0, then goes to SUSTAIN; output is silent.
REQ-023 Capture and tick in the same cycle: the capture transition wins and the tick is discarded for the envelope.
REQ-024 tune=0: phase frozen; wave is constant at the current t scaled by env.

Reset
REQ-025 While reset_n is low: FSM=IDLE, env=0, phase=0, prescaler=0, latched word=0, synchronizer flops=0, wave=32, busy=0.
REQ-026 A reset asserted mid-note aborts the note immediately with no release ramp; no capture is generated on deassertion, even if load is high.

Structure
REQ-027 A shared package piano_pkg shall hold: the env_state_t enum; word field bit positions; the WAVE_MID=6'd32 constant.
REQ-028 Single sub-module sync_edge: a 2-FF synchronizer plus rising-edge detector producing a one-clk pulse; everything else is flat.

Verification (RATE_DIV=4)
REQ-029 Reset: drive reset_n low mid-SUSTAIN -> wave=32 and busy=0 asynchronously; after release with load held high, there is no capture.
REQ-030 Note on: load 0x8F800000 -> busy rises 4 clk after load; env reaches 15 after 15 ticks (60 clk) -> SUSTAIN; wave peaks at 61, troughs at 2, period 512 clk.
REQ-031 Note off: load 0x0F800000 in SUSTAIN -> RELEASE; env reaches 0 after 60 clk -> IDLE, busy=0, wave=32.
REQ-032 Re-trigger: load 0x88800000 during RELEASE at env=10 -> ATTACK stepping down 10->9->8 -> SUSTAIN at 8, with no jump to 0.
REQ-033 Long strobe: load held 50 clk -> exactly one capture; a capture coinciding with a tick -> env unchanged that cycle.
REQ-034 Zero cases: load 0x80800000 (volume 0) -> SUSTAIN, wave stays 32; load 0x8F000000 (tune 0) -> wave constant.
